// File: rtl/bnn_accum_ctrl_pkg.sv
// Shared types and constants for the binary neural-net accumulate controller.
package bnn_accum_ctrl_pkg;

   localparam int unsigned ACC_WIDTH_DEF = 12;

   localparam logic ALU_OP_ADD1 = 1'b0;
   localparam logic ALU_OP_SUB1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bnn_accum_ctrl_alu.sv
// Increment/decrement ALU: passes alu_in_b through when the activation bit is 0.
module bnn_accum_ctrl_alu
   import bnn_accum_ctrl_pkg::*;
#(
   parameter int unsigned alu_width = ACC_WIDTH_DEF
) (
   input  logic                        alu_in_a_lsb,
   input  logic                        alu_op,
   input  logic signed [alu_width-1:0] alu_in_b,
   output logic signed [alu_width-1:0] alu_out_c
);

   always_comb begin
      alu_out_c = alu_in_b;
      if (alu_in_a_lsb) begin
         if (alu_op == ALU_OP_SUB1) begin
            alu_out_c = alu_in_b - alu_width'(1);
         end else begin
            alu_out_c = alu_in_b + alu_width'(1);
         end
      end
   end

endmodule

// File: rtl/bnn_accum_ctrl.sv
// Serial binary dot-product accumulator: one activation/weight pair per RUN cycle,
// result held in DONE until the downstream handshake.
module bnn_accum_ctrl
   import bnn_accum_ctrl_pkg::*;
#(
   parameter int unsigned VEC_LEN   = 16,
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [VEC_LEN-1:0]          in_act,
   input  logic [VEC_LEN-1:0]          in_wgt,
   input  logic signed [ACC_WIDTH-1:0] in_bias,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_WIDTH-1:0] out_acc,
   output logic                        busy
);

   localparam int unsigned CNT_W = $clog2(VEC_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

   state_t                      state_q, state_d;
   logic [VEC_LEN-1:0]          act_sr_q, act_sr_d;
   logic [VEC_LEN-1:0]          wgt_sr_q, wgt_sr_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        in_ready_q, in_ready_d;
   logic                        out_valid_q, out_valid_d;
   logic                        busy_q, busy_d;
   logic signed [ACC_WIDTH-1:0] out_acc_q, out_acc_d;

   logic                        alu_in_a_lsb;
   logic                        alu_op;
   logic signed [ACC_WIDTH-1:0] alu_in_b;
   logic signed [ACC_WIDTH-1:0] alu_out;

   assign alu_in_a_lsb = act_sr_q[0];
   assign alu_op       = wgt_sr_q[0];
   assign alu_in_b     = acc_q;

   bnn_accum_ctrl_alu #(
      .alu_width (ACC_WIDTH)
   ) u_alu (
      .alu_in_a_lsb (alu_in_a_lsb),
      .alu_op       (alu_op),
      .alu_in_b     (alu_in_b),
      .alu_out_c    (alu_out)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      act_sr_d    = act_sr_q;
      wgt_sr_d    = wgt_sr_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      out_acc_d   = out_acc_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               act_sr_d   = in_act;
               wgt_sr_d   = in_wgt;
               acc_d      = in_bias;
               cnt_d      = '0;
               state_d    = RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         RUN: begin
            acc_d    = alu_out;
            act_sr_d = act_sr_q >> 1;
            wgt_sr_d = wgt_sr_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_acc_d   = alu_out;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               out_acc_d   = '0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_acc_d   = '0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         act_sr_q    <= '0;
         wgt_sr_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_acc_q   <= '0;
      end else begin
         state_q     <= state_d;
         act_sr_q    <= act_sr_d;
         wgt_sr_q    <= wgt_sr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         out_acc_q   <= out_acc_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_acc   = out_acc_q;

endmodule

// File: doc/bnn_accum_ctrl.md
BNN_ACCUM_CTRL -- requirements
Module: bnn_accum_ctrl

Interface
REQ-001 SHALL have parameter VEC_LEN, default 16: number of activation/weight bit pairs per dot product.
REQ-002 SHALL have parameter ACC_WIDTH, default 12: signed accumulator width, matching the alu width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: the upstream job is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a job.
REQ-007 SHALL have port in_act, input, VEC_LEN: activation bits; bit 0 is consumed first.
REQ-008 SHALL have port in_wgt, input, VEC_LEN: weight bits; 0 means add, 1 means subtract.
REQ-009 SHALL have port in_bias, input, ACC_WIDTH signed: initial accumulator value.
REQ-010 SHALL have port out_valid, output, 1: the result is valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port out_acc, output, ACC_WIDTH signed: the final accumulated result.
REQ-013 SHALL have port busy, output, 1: high in RUN or DONE.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-016 A job SHALL be accepted on an edge where in_valid && in_ready; in_act/in_wgt SHALL load into internal shift registers, acc SHALL load in_bias, the bit counter SHALL clear, and the FSM SHALL go to RUN.
REQ-017 In each RUN cycle, the block SHALL drive alu_in_a_lsb = act_sr[0], alu_op = wgt_sr[0] and alu_in_b = acc; acc SHALL take alu_out; both shift registers SHALL shift right by 1; the counter SHALL increment.
REQ-018 Arithmetic SHALL be two's-complement, ACC_WIDTH bits, and wrap without saturation; an activation bit of 0 SHALL leave acc unchanged regardless of the weight bit.
REQ-019 On the RUN edge where counter == VEC_LEN-1, the FSM SHALL go to DONE after applying the final update; exactly VEC_LEN updates SHALL occur per job.
REQ-020 Latency: out_valid SHALL first be high in the cycle following the VEC_LEN-th edge after the accepting edge.
REQ-021 In DONE, out_valid SHALL be 1 and out_acc SHALL equal acc, held stable until out_valid && out_ready.
REQ-022 On out_valid && out_ready, the FSM SHALL go to IDLE; in_ready SHALL rise the following cycle (no same-cycle accept-on-drain).
REQ-023 In_valid asserted during RUN/DONE SHALL be ignored, and inputs SHALL not be sampled outside IDLE.
REQ-024 out_acc SHALL be registered and drive 0 outside DONE.

Reset
REQ-025 While rst_n == 0, state SHALL be IDLE and acc, counter, shift registers and out_acc SHALL be 0; out_valid SHALL be 0, busy SHALL be 0 and in_ready SHALL be 1 after deassertion.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL abort the job immediately; no out_valid SHALL be produced for it.

Structure
REQ-027 The shared package SHALL hold ALU_OP_ADD1 = 1'b0, ALU_OP_SUB1 = 1'b1, the state enum (IDLE/RUN/DONE) and the ACC_WIDTH default.
REQ-028 The block SHALL instantiate exactly one existing alu sub-module with alu_width = ACC_WIDTH, and SHALL contain no other arithmetic on acc.
REQ-029 The counter width SHALL be $clog2(VEC_LEN)+1.

Verification
REQ-030 in_act = 16'hFFFF, in_wgt = 16'h0000, bias = 0 -> out_acc = 16, 16 edges after accept.
REQ-031 in_act = 16'hFFFF, in_wgt = 16'hFFFF, bias = 5 -> out_acc = -11.
REQ-032 in_act = 16'h0000, any wgt, bias = -300 -> out_acc = -300.
REQ-033 Wrap: in_act = 16'hFFFF, in_wgt = 0, bias = 2047 -> out_acc = -2033.
REQ-034 out_ready held low 5 cycles in DONE, with in_valid high throughout -> out_acc stable, in_ready stays 0, and the second job is accepted only after the handshake plus 1 cycle.
REQ-035 rst_n pulsed low at the 8th RUN cycle -> immediate return to IDLE with outputs 0, no out_valid; the next job (act = 16'h00FF, wgt = 16'h000F, bias = 0) -> out_acc = 0.
